// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word reader: FSM state encoding,
// default byte width and the byte-counter width helper.
package uart_pkg;

  localparam int DBIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Width of a counter that must be able to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_word_timeout.sv
// Inter-byte timeout counter for uart_word_reader: counts while run is high,
// clears whenever run drops, and flags expiry on the TIMEOUT_CYCLES-th cycle.
module uart_word_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == LAST);

  // Wrapping back to zero on expiry keeps a stale count from leaking into the next word.
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_reader.sv
// Pops bytes from the UART RX FIFO and assembles WORD_BYTES of them into one
// word offered on a valid/ready handshake. Optional timeout: UART_WORD_TIMEOUT_EN.
module uart_word_reader
  import uart_pkg::*;
#(
  parameter int DBIT           = DBIT_DEFAULT,
  parameter int WORD_BYTES     = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rx_empty,
  input  logic [DBIT-1:0]                  r_data,
  output logic                             rd_uart,
  input  logic                             flush,
  output logic [DBIT*WORD_BYTES-1:0]       word,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic [cnt_width(WORD_BYTES)-1:0] byte_cnt,
  output logic                             timeout_err
);

  localparam int            CW   = cnt_width(WORD_BYTES);
  localparam logic [CW-1:0] FULL = CW'(WORD_BYTES);

  state_e                     state_q, state_d;
  logic [CW-1:0]              byte_cnt_q, byte_cnt_d;
  logic [DBIT*WORD_BYTES-1:0] word_q, word_d;
  logic                       timeout_hit;
  int                         slot;

`ifdef UART_WORD_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;
  logic partial;

  assign partial = (byte_cnt_q != '0) && (byte_cnt_q != FULL);

  uart_word_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .run   ((state_q == WAIT) && partial),
    .expire(timeout_hit)
  );

  always_comb begin
    timeout_err_d = timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign rd_uart    = (state_q == REQ);
  assign word_valid = (state_q == HOLD);
  assign word       = word_q;
  assign byte_cnt   = byte_cnt_q;

  // A timeout in WAIT beats a newly available byte; that byte starts a fresh word next cycle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    slot       = MSB_FIRST ? (WORD_BYTES - 1 - int'(byte_cnt_q)) : int'(byte_cnt_q);
    case (state_q)
      WAIT: begin
        if (flush || timeout_hit) begin
          byte_cnt_d = '0;
        end else if (!rx_empty) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          byte_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        state_d = WAIT;
        if (flush) begin
          byte_cnt_d = '0;
        end else begin
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (i == slot) begin
              word_d[i*DBIT +: DBIT] = r_data;
            end
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_d == FULL) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          byte_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      default: begin
        state_d = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: tb/tb_uart_word_reader.sv
// Bench for uart_word_reader: an MSB-first and an LSB-first instance share one
// byte stream, each fed by its own FIFO model; expected words go through a scoreboard.
`timescale 1ns/1ps
module tb_uart_word_reader;

  localparam int            DBIT     = 8;
  localparam int            WB       = 4;
  localparam int            TO       = 50;
  localparam int            WW       = DBIT * WB;
  localparam int            CW       = $clog2(WB + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WB);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            word_ready = 1'b0;
  logic            push_en = 1'b0;
  logic [7:0]      push_data = 8'h00;
  logic            rx_empty_m = 1'b1, rx_empty_l = 1'b1;
  logic [7:0]      r_data_m = 8'h00, r_data_l = 8'h00;
  logic            rd_uart_m, rd_uart_l, word_valid_m, word_valid_l;
  logic            timeout_err_m, timeout_err_l;
  logic [WW-1:0]   word_m, word_l;
  logic [CW-1:0]   byte_cnt_m, byte_cnt_l;

  logic [7:0]      fifo_m[$], fifo_l[$];
  logic [WW-1:0]   exp_m[$], exp_l[$];

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, rd_cnt_m = 0, empty_viol = 0, hold_viol = 0;

  always #5 clk = ~clk;

  uart_word_reader #(.DBIT(DBIT), .WORD_BYTES(WB), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) dut_m (
    .clk(clk), .reset(reset), .rx_empty(rx_empty_m), .r_data(r_data_m), .rd_uart(rd_uart_m),
    .flush(flush), .word(word_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .byte_cnt(byte_cnt_m), .timeout_err(timeout_err_m));

  uart_word_reader #(.DBIT(DBIT), .WORD_BYTES(WB), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(TO)) dut_l (
    .clk(clk), .reset(reset), .rx_empty(rx_empty_l), .r_data(r_data_l), .rd_uart(rd_uart_l),
    .flush(flush), .word(word_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .byte_cnt(byte_cnt_l), .timeout_err(timeout_err_l));

  // FIFO models: read data appears the cycle after rd_uart, empty flag is registered.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart_m && fifo_m.size() != 0) r_data_m <= fifo_m.pop_front();
    if (push_en) fifo_m.push_back(push_data);
    rx_empty_m <= (fifo_m.size() == 0);
    if (rd_uart_l && fifo_l.size() != 0) r_data_l <= fifo_l.pop_front();
    if (push_en) fifo_l.push_back(push_data);
    rx_empty_l <= (fifo_l.size() == 0);
  end

  always @(negedge clk) begin
    if (rd_uart_m) rd_cnt_m++;
    if ((rd_uart_m && rx_empty_m) || (rd_uart_l && rx_empty_l)) empty_viol++;
    if ((rd_uart_m && word_valid_m) || (rd_uart_l && word_valid_l)) hold_viol++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [WW-1:0] swap_bytes(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < WB; i++) r[8*i +: 8] = w[WW-8-8*i +: 8];
    return r;
  endfunction

  function automatic logic [WW-1:0] pop_m();
    if (exp_m.size() != 0) return exp_m.pop_front();
    return 'x;
  endfunction

  function automatic logic [WW-1:0] pop_l();
    if (exp_l.size() != 0) return exp_l.pop_front();
    return 'x;
  endfunction

  task automatic expect_word(input logic [WW-1:0] w);
    exp_m.push_back(w);
    exp_l.push_back(swap_bytes(w));
  endtask

  // Pushes the top n bytes of w, most significant first, one per cycle.
  task automatic push_word(input logic [WW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_en   = 1'b1;
      push_data = w[(WW-1-8*i) -: 8];
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (word_valid_m) got = 1'b1;
    end
  endtask

  task automatic wait_cnt(input logic [CW-1:0] n, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (byte_cnt_m == n) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (word_m !== '0 || word_l !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_word: got %h/%h expected 0", word_m, word_l);
    end
    tests_run++;
    if (word_valid_m !== 1'b0 || rd_uart_m !== 1'b0 || word_valid_l !== 1'b0 || rd_uart_l !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: valid %b rd %b expected 0 0", word_valid_m, rd_uart_m);
    end
    tests_run++;
    if (byte_cnt_m !== '0 || timeout_err_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt: byte_cnt %0d timeout_err %b expected 0 0", byte_cnt_m, timeout_err_m);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit got;
    int rd0, t0, lat;
    logic [WW-1:0] e_m, e_l;
    word_ready = 1'b1;
    rd0 = rd_cnt_m;
    t0  = cyc;
    expect_word(32'h12345678);
    push_word(32'h12345678, 4);
    wait_valid(100, got);
    lat = cyc - t0;
    e_m = pop_m();
    e_l = pop_l();
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL basic_valid: word_valid never rose within 100 cycles");
    end
    tests_run++;
    if (word_m !== e_m) begin
      tests_failed++;
      $display("[TB] FAIL basic_msb_word: got %h expected %h", word_m, e_m);
    end
    tests_run++;
    if (word_l !== e_l) begin
      tests_failed++;
      $display("[TB] FAIL basic_lsb_word: got %h expected %h", word_l, e_l);
    end
    tests_run++;
    if (lat < 3 * WB) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected at least %0d", lat, 3 * WB);
    end
    @(negedge clk);
    tests_run++;
    if (word_valid_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_valid_pulse: word_valid %b one cycle later, expected 0", word_valid_m);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (rd_cnt_m - rd0 != 4 || byte_cnt_m !== '0) begin
      tests_failed++;
      $display("[TB] FAIL basic_reads: rd pulses %0d byte_cnt %0d expected 4 0", rd_cnt_m - rd0, byte_cnt_m);
    end
  endtask

  task automatic test_back_to_back();
    bit got, stable;
    int rd0, hv0;
    logic [WW-1:0] e_m, e_l;
    word_ready = 1'b0;
    rd0 = rd_cnt_m;
    hv0 = hold_viol;
    expect_word(32'h01020304);
    expect_word(32'h05060708);
    push_word(32'h01020304, 4);
    push_word(32'h05060708, 4);
    wait_valid(100, got);
    e_m = pop_m();
    e_l = pop_l();
    tests_run++;
    if (!got || word_m !== e_m || word_l !== e_l) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: valid %b got %h/%h expected %h/%h", got, word_m, word_l, e_m, e_l);
    end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!word_valid_m || word_m !== e_m) stable = 1'b0;
    end
    tests_run++;
    if (!stable || byte_cnt_m !== FULL_CNT) begin
      tests_failed++;
      $display("[TB] FAIL b2b_hold: stable %b byte_cnt %0d expected 1 %0d", stable, byte_cnt_m, WB);
    end
    word_ready = 1'b1;
    wait_valid(100, got);
    e_m = pop_m();
    e_l = pop_l();
    tests_run++;
    if (!got || word_m !== e_m || word_l !== e_l) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: valid %b got %h/%h expected %h/%h", got, word_m, word_l, e_m, e_l);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (rd_cnt_m - rd0 != 8 || hold_viol != hv0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_reads: rd pulses %0d hold reads %0d expected 8 0", rd_cnt_m - rd0, hold_viol - hv0);
    end
  endtask

  task automatic test_flush();
    bit got;
    int extra;
    logic [WW-1:0] e_m, e_l;
    word_ready = 1'b1;
    push_word(32'hAABB0000, 2);
    wait_cnt(CW'(2), 50, got);
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL flush_partial: byte_cnt %0d expected 2", byte_cnt_m);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (byte_cnt_m !== '0) begin
      tests_failed++;
      $display("[TB] FAIL flush_cnt: byte_cnt %0d expected 0", byte_cnt_m);
    end
    expect_word(32'h11223344);
    push_word(32'h11223344, 4);
    wait_valid(100, got);
    e_m = pop_m();
    e_l = pop_l();
    tests_run++;
    if (!got || word_m !== e_m || word_l !== e_l) begin
      tests_failed++;
      $display("[TB] FAIL flush_word: valid %b got %h/%h expected %h/%h", got, word_m, word_l, e_m, e_l);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (word_valid_m || word_valid_l) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("[TB] FAIL flush_extra: %0d extra valid cycles, expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int extra;
    logic [WW-1:0] e_m, e_l;
    word_ready = 1'b1;
    push_word(32'hC1C2C300, 3);
    wait_cnt(CW'(3), 50, got);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (!got || byte_cnt_m !== '0 || word_m !== '0 || word_l !== '0 || word_valid_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear: reached %b byte_cnt %0d word %h/%h valid %b expected 1 0 0 0 0",
               got, byte_cnt_m, word_m, word_l, word_valid_m);
    end
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (word_valid_m || rd_uart_m || byte_cnt_m != '0) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_idle: %0d active cycles after release, expected 0", extra);
    end
    expect_word(32'hDEADBEEF);
    push_word(32'hDEADBEEF, 4);
    wait_valid(100, got);
    e_m = pop_m();
    e_l = pop_l();
    tests_run++;
    if (!got || word_m !== e_m || word_l !== e_l) begin
      tests_failed++;
      $display("[TB] FAIL midreset_word: valid %b got %h/%h expected %h/%h", got, word_m, word_l, e_m, e_l);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit got;
    int pulses_m, pulses_l, at;
    word_ready = 1'b1;
    push_word(32'h5A000000, 1);
    wait_cnt(CW'(1), 50, got);
    pulses_m = 0;
    pulses_l = 0;
    at = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (timeout_err_m) begin
        pulses_m++;
        if (at < 0) at = i;
      end
      if (timeout_err_l) pulses_l++;
    end
`ifdef UART_WORD_TIMEOUT_EN
    tests_run++;
    if (!got || pulses_m != 1 || pulses_l != 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_pulses: got %0d/%0d expected 1/1", pulses_m, pulses_l);
    end
    tests_run++;
    if (at < TO - 5 || at > TO + 5) begin
      tests_failed++;
      $display("[TB] FAIL timeout_delay: pulse at %0d cycles expected about %0d", at, TO);
    end
    tests_run++;
    if (byte_cnt_m !== '0 || byte_cnt_l !== '0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cnt: byte_cnt %0d/%0d expected 0", byte_cnt_m, byte_cnt_l);
    end
`else
    tests_run++;
    if (!got || pulses_m != 0 || pulses_l != 0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_pulses: got %0d/%0d expected 0/0", pulses_m, pulses_l);
    end
    tests_run++;
    if (byte_cnt_m !== CW'(1) || byte_cnt_l !== CW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cnt: byte_cnt %0d/%0d expected 1", byte_cnt_m, byte_cnt_l);
    end
`endif
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (byte_cnt_m !== '0 || word_valid_m !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cleanup: byte_cnt %0d valid %b expected 0 0", byte_cnt_m, word_valid_m);
    end
  endtask

  task automatic test_final();
    tests_run++;
    if (empty_viol != 0 || exp_m.size() != 0 || exp_l.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL final: reads-while-empty %0d pending words %0d/%0d expected 0 0/0",
               empty_viol, exp_m.size(), exp_l.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_timeout();
    test_final();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
